// File: rtl/note_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// note_scheduler_pkg
// Shared definitions for the arrow-note scheduler:
//   - state_t   : scheduler FSM encoding (IDLE / ARMED / COOLDOWN)
//   - GAP_TABLE : Level -> cooldown length in Ticks (8, 4, 2, 1)
//   - gap_of()  : table lookup for a 2-bit Level
//   - lane_of() : one-hot lane vector -> lane index
// ---------------------------------------------------------------------------
package note_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int LANE_N = 4;
  localparam int CD_W   = 4;

  // Packed table, entry n occupies bits [4n+3:4n]; Level 0 is the easiest
  // setting and therefore the longest gap.
  localparam logic [4*CD_W-1:0] GAP_TABLE = {4'd1, 4'd2, 4'd4, 4'd8};

  function automatic logic [CD_W-1:0] gap_of(input logic [1:0] level);
    return GAP_TABLE[{level, 2'b00} +: CD_W];
  endfunction

  function automatic logic [1:0] lane_of(input logic [LANE_N-1:0] onehot);
    logic [1:0] idx;
    case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/note_scheduler_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4
// Combinational 4-lane round-robin arbiter. The search begins at the lane
// after the last granted one and wraps 3 -> 0, so the last granted lane is
// considered last.
// Ports:
//   req   [3:0] in  : request vector, one bit per lane
//   last  [1:0] in  : index of the most recently granted lane
//   en          in  : when low, no grant is produced
//   grant [3:0] out : one-hot grant (all zero if disabled or no request)
// ---------------------------------------------------------------------------
module rr_arbiter_4
  import note_scheduler_pkg::*;
(
  input  logic [LANE_N-1:0] req,
  input  logic [1:0]        last,
  input  logic              en,
  output logic [LANE_N-1:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    if (en) begin
      // Offsets 1..4; the 2-bit add wraps naturally, offset 4 lands on 'last'.
      for (int i = 1; i <= LANE_N; i++) begin
        idx = last + 2'(i);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// ---------------------------------------------------------------------------
// note_scheduler
// Decides when and in which lane a rhythm-game arrow is spawned. Timing is
// counted in game-frame Ticks. While ARMED, a Tick with any random lane
// request grants one lane (round-robin) and enters COOLDOWN for a gap set by
// Level; the Tick that ends the cooldown cannot spawn.
// Ports:
//   Clock            in  : clock, rising edge
//   Reset            in  : synchronous active-high reset
//   Start            in  : level, begins a session from IDLE
//   Stop             in  : level, returns to IDLE from any state
//   Tick             in  : one-cycle frame strobe
//   Rand  [LANES-1:0] in : per-lane spawn requests
//   Level [1:0]      in  : difficulty, selects cooldown gap
//   Spawn [LANES-1:0] out: registered one-hot spawn pulse
//   Active           out : high in ARMED or COOLDOWN
//   SpawnCount [CNT_W-1:0] out : saturating count of spawns this session
// Only LANES = 4 is supported.
// ---------------------------------------------------------------------------
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Tick,
  input  logic [LANES-1:0] Rand,
  input  logic [1:0]       Level,
  output logic [LANES-1:0] Spawn,
  output logic             Active,
  output logic [CNT_W-1:0] SpawnCount
);

  state_t            state, state_nxt;
  logic [1:0]        last_ptr, ptr_nxt;
  logic [CD_W-1:0]   cd_cnt, cd_nxt;
  logic [LANES-1:0]  spawn_nxt;
  logic              active_nxt;
  logic [CNT_W-1:0]  count_nxt;

  logic              grant_en;
  logic [LANES-1:0]  grant;

  // Stop is folded into the enable so a coincident Stop suppresses the grant.
  assign grant_en = (state == ST_ARMED) && Tick && !Stop;

  rr_arbiter_4 u_arb (
    .req   (Rand),
    .last  (last_ptr),
    .en    (grant_en),
    .grant (grant)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = last_ptr;
    cd_nxt    = cd_cnt;
    spawn_nxt = '0;
    count_nxt = SpawnCount;

    if (Stop) begin
      state_nxt = ST_IDLE;
      cd_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state_nxt = ST_ARMED;
            count_nxt = '0;
          end
        end
        ST_ARMED: begin
          if (|grant) begin
            spawn_nxt = grant;
            ptr_nxt   = lane_of(grant);
            cd_nxt    = gap_of(Level);
            state_nxt = ST_COOLDOWN;
            if (SpawnCount != {CNT_W{1'b1}})
              count_nxt = SpawnCount + CNT_W'(1);
          end
        end
        ST_COOLDOWN: begin
          if (Tick) begin
            // A counter at 0 can only arise from corruption; treat it like 1.
            if (cd_cnt <= CD_W'(1)) begin
              state_nxt = ST_ARMED;
              cd_nxt    = '0;
            end else begin
              cd_nxt = cd_cnt - CD_W'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cd_nxt    = '0;
        end
      endcase
    end

    active_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      last_ptr   <= 2'd3;
      cd_cnt     <= '0;
      Spawn      <= '0;
      Active     <= 1'b0;
      SpawnCount <= '0;
    end else begin
      state      <= state_nxt;
      last_ptr   <= ptr_nxt;
      cd_cnt     <= cd_nxt;
      Spawn      <= spawn_nxt;
      Active     <= active_nxt;
      SpawnCount <= count_nxt;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// ---------------------------------------------------------------------------
// tb_note_scheduler
// Self-checking bench for note_scheduler: a per-cycle vector table for the
// round-robin, idle-tick, Stop and Level-hold cases, plus hand-written
// sequences for slow Ticks, reset mid-cooldown and counter saturation.
// ---------------------------------------------------------------------------
module tb_note_scheduler;

  logic       Clock = 1'b0;
  logic       Reset, Start, Stop, Tick;
  logic [3:0] Rand;
  logic [1:0] Level;
  logic [3:0] Spawn;
  logic       Active;
  logic [7:0] SpawnCount;

  note_scheduler #(.LANES(4), .CNT_W(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Stop       (Stop),
    .Tick       (Tick),
    .Rand       (Rand),
    .Level      (Level),
    .Spawn      (Spawn),
    .Active     (Active),
    .SpawnCount (SpawnCount)
  );

  always #5 Clock = ~Clock;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [3:0] prev_spawn = 4'b0;

  typedef struct {
    int         due;
    logic [3:0] val;
  } sb_t;
  sb_t sbq[$];
  bit  sb_on = 1'b0;

  typedef struct {
    logic       start, stop, tick;
    logic [3:0] rnd;
    logic [1:0] lvl;
    logic [3:0] e_spawn;
    logic       e_active;
    logic [7:0] e_count;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply inputs for one clock, then sample just after the edge.
  task automatic step(input logic st, input logic sp, input logic tk,
                      input logic [3:0] rd, input logic [1:0] lv);
    Start = st; Stop = sp; Tick = tk; Rand = rd; Level = lv;
    @(posedge Clock);
    #1;
    cyc++;
    chk("spawn_onehot0", 32'($onehot0(Spawn)), 32'd1);
    chk("spawn_not_back_to_back", 32'((Spawn != 4'b0) && (prev_spawn != 4'b0)), 32'd0);
    prev_spawn = Spawn;
    if (sb_on) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("sb_spawn", 32'(Spawn), 32'(sbq[0].val));
        void'(sbq.pop_front());
      end else if (Spawn != 4'b0) begin
        chk("sb_unexpected_spawn", 32'(Spawn), 32'd0);
      end
    end
  endtask

  // Reset is held against Start/Tick/Rand activity to show it dominates.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 4'b1111, 2'd0);
    Reset = 1'b0;
    chk({tag, "_spawn"},  32'(Spawn),      32'd0);
    chk({tag, "_active"}, 32'(Active),     32'd0);
    chk({tag, "_count"},  32'(SpawnCount), 32'd0);
  endtask

  task automatic add(input logic st, input logic sp, input logic tk, input logic [3:0] rd,
                     input logic [1:0] lv, input logic [3:0] es, input logic ea,
                     input logic [7:0] ec);
    vec_t v;
    v.start = st; v.stop = sp; v.tick = tk; v.rnd = rd; v.lvl = lv;
    v.e_spawn = es; v.e_active = ea; v.e_count = ec;
    tbl.push_back(v);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Tick = 1'b0; Rand = 4'b0; Level = 2'd0;

    // ---------------- vector table ----------------
    //   st sp tk rand     lvl  spawn   act cnt
    add(1, 0, 0, 4'b0000, 3, 4'b0000, 1, 0);  // start -> ARMED, count cleared
    add(0, 0, 1, 4'b1111, 3, 4'b0001, 1, 1);  // lane 0 first after reset
    add(0, 0, 1, 4'b1111, 3, 4'b0000, 1, 1);  // cooldown tick, no spawn
    add(0, 0, 1, 4'b1111, 3, 4'b0010, 1, 2);
    add(0, 0, 1, 4'b1111, 3, 4'b0000, 1, 2);
    add(0, 0, 1, 4'b1111, 3, 4'b0100, 1, 3);
    add(0, 0, 1, 4'b1111, 3, 4'b0000, 1, 3);
    add(0, 0, 1, 4'b1111, 3, 4'b1000, 1, 4);
    add(0, 0, 1, 4'b1111, 3, 4'b0000, 1, 4);
    add(0, 0, 1, 4'b1111, 3, 4'b0001, 1, 5);  // wrap 3 -> 0
    add(0, 0, 1, 4'b1010, 3, 4'b0000, 1, 5);  // end of cooldown
    add(0, 0, 0, 4'b1010, 3, 4'b0000, 1, 5);  // Rand without Tick ignored
    add(0, 0, 1, 4'b0000, 3, 4'b0000, 1, 5);  // Tick without Rand
    add(0, 0, 1, 4'b0010, 3, 4'b0010, 1, 6);  // grant lane 1
    add(0, 0, 1, 4'b1010, 3, 4'b0000, 1, 6);
    add(0, 0, 1, 4'b1010, 3, 4'b1000, 1, 7);  // after lane 1 -> lane 3
    add(0, 0, 1, 4'b1010, 3, 4'b0000, 1, 7);
    add(0, 0, 1, 4'b1010, 3, 4'b0010, 1, 8);  // then lane 1
    add(0, 0, 1, 4'b1010, 3, 4'b0000, 1, 8);
    add(0, 1, 1, 4'b0001, 3, 4'b0000, 0, 8);  // Stop beats grant
    add(0, 0, 1, 4'b1111, 3, 4'b0000, 0, 8);  // IDLE: no spawn, count held
    add(1, 1, 0, 4'b0000, 3, 4'b0000, 0, 8);  // Stop beats Start
    add(1, 0, 0, 4'b0000, 3, 4'b0000, 1, 0);  // new session clears count
    add(0, 0, 1, 4'b0100, 0, 4'b0100, 1, 1);  // grant at Level 0 -> gap 8
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 4'b1111, 3, 4'b0000, 1, 1); // Level change must not shorten
    add(0, 0, 1, 4'b1111, 3, 4'b1000, 1, 2);  // next lane after 2 is 3
    add(0, 1, 0, 4'b0000, 3, 4'b0000, 0, 2);  // Stop from ARMED/COOLDOWN

    do_reset("reset0");
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].tick, tbl[i].rnd, tbl[i].lvl);
      chk($sformatf("vec%0d_spawn", i),  32'(Spawn),      32'(tbl[i].e_spawn));
      chk($sformatf("vec%0d_active", i), 32'(Active),     32'(tbl[i].e_active));
      chk($sformatf("vec%0d_count", i),  32'(SpawnCount), 32'(tbl[i].e_count));
    end

    // ---------------- slow Ticks, Level 0, single lane ----------------
    do_reset("reset1");
    sb_on = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'b0001, 2'd0);
    for (int k = 1; k <= 20; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0 && (k == 1 || k == 10 || k == 19))
          sbq.push_back('{cyc + 1, 4'b0001});
        step(1'b0, 1'b0, (c == 0), 4'b0001, 2'd0);
      end
    end
    sb_on = 1'b0;
    chk("slow_tick_count", 32'(SpawnCount), 32'd3);
    chk("slow_tick_sb_drained", 32'(sbq.size()), 32'd0);

    // ---------------- reset mid-cooldown ----------------
    do_reset("reset_mid_cd");
    step(1'b1, 1'b0, 1'b0, 4'b1000, 2'd0);
    chk("restart_active", 32'(Active), 32'd1);
    step(1'b0, 1'b0, 1'b1, 4'b1000, 2'd0);
    chk("restart_spawn", 32'(Spawn), 32'b1000);
    chk("restart_count", 32'(SpawnCount), 32'd1);

    // ---------------- SpawnCount saturation ----------------
    do_reset("reset_sat");
    step(1'b1, 1'b0, 1'b0, 4'b0000, 2'd3);
    for (int i = 0; i < 509; i++)
      step(1'b0, 1'b0, 1'b1, 4'b1111, 2'd3);
    chk("sat_reach_255", 32'(SpawnCount), 32'd255);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 2'd3);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 2'd3);
    chk("sat_grant_issued", 32'(Spawn != 4'b0), 32'd1);
    chk("sat_hold_255", 32'(SpawnCount), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter LANES, default 4: number of arrow lanes; only 4 is supported.
REQ-002 Parameter CNT_W, default 8: width of the spawn counter.
REQ-003 Port Clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1: synchronous, active-high reset.
REQ-005 Port Start  input  1: level; begins a song session when in IDLE.
REQ-006 Port Stop  input  1: level; aborts the session from any state.
REQ-007 Port Tick  input  1: one-cycle game-frame strobe; all timing below counts Ticks, not clocks.
REQ-008 Port Rand  input  4: per-lane random spawn requests, one bit per lane, from the LFSR press generators.
REQ-009 Port Level  input  2: difficulty; selects the cooldown gap.
REQ-010 Port Spawn  output  4: registered one-hot arrow spawn pulse, high for exactly one clock.
REQ-011 Port Active  output  1: high while the state is ARMED or COOLDOWN.
REQ-012 Port SpawnCount  output  CNT_W: number of arrows spawned this session.

Function
REQ-013 States: IDLE, ARMED, COOLDOWN.
REQ-014 IDLE: Start=1 and Stop=0 -> ARMED next cycle; SpawnCount cleared to 0 on the same edge.
REQ-015 ARMED: Tick=1 and Rand!=0 -> grant exactly one requesting lane; Spawn shows the grant on the next cycle; go to COOLDOWN.
REQ-016 ARMED: Tick=0, or Tick=1 with Rand=0 -> no spawn; stay ARMED.
REQ-017 Rand is ignored in all cycles without Tick and in all states other than ARMED.
REQ-018 Grant is round-robin: the search starts at the lane after the last granted lane and wraps 3 -> 0.
REQ-019 After reset, lane 0 has highest priority, i.e. the last-granted pointer is 3.
REQ-020 On each grant, the cooldown counter is loaded from Level, sampled on the grant cycle: 0 -> 8, 1 -> 4, 2 -> 2, 3 -> 1.
REQ-021 COOLDOWN: each Tick decrements the counter; the Tick that finds the counter at 1 returns the state to ARMED.
REQ-022 The Tick that returns to ARMED cannot itself spawn; the earliest next spawn is on the following Tick.
REQ-023 Consequence of REQ-021/022: minimum spacing between spawns is gap+1 Ticks.
REQ-024 Level changes during COOLDOWN do not affect the loaded count.
REQ-025 Each grant increments SpawnCount; SpawnCount saturates at 2^CNT_W-1 and never wraps.
REQ-026 Stop=1 in any state -> IDLE next cycle; Stop has priority over Start and over a coincident grant (no Spawn is issued).
REQ-027 In IDLE, Spawn=0 and SpawnCount holds its last value.
REQ-028 Spawn is never multi-hot and is never asserted on two consecutive clocks.

Reset
REQ-029 Reset has priority over all inputs and gives: state IDLE, Spawn=0, Active=0, SpawnCount=0, cooldown counter 0, last-granted pointer 3.
REQ-030 Reset asserted during ARMED or COOLDOWN discards any pending grant and any cooldown in progress.

Structure
REQ-031 A shared package holds the state encoding and the Level-to-gap constant table (8, 4, 2, 1).
REQ-032 The round-robin grant logic is one sub-module, rr_arbiter_4: inputs are the request vector, the last-grant pointer and an enable; output is a one-hot grant.
REQ-033 All outputs are driven directly from registers.

Verification
REQ-034 Reset, Start=1, Level=0, Tick every 4 clocks, Rand=4'b0001 constant -> Spawn=0001 on Ticks 1, 10, 19; SpawnCount=3.
REQ-035 Rand=4'b1111, Level=3, Tick every clock -> Spawn sequence 0001, 0010, 0100, 1000, 0001 with one idle Tick between spawns.
REQ-036 Rand=4'b1010 after a grant to lane 1 -> next grant is lane 3, then lane 1.
REQ-037 Stop asserted on the same cycle as a Tick with Rand=0001 in ARMED -> no Spawn, IDLE next cycle, Active=0.
REQ-038 Force SpawnCount to 255 (CNT_W=8) and cause one more grant -> SpawnCount stays 255.
REQ-039 Reset pulse mid-COOLDOWN at Level=0 -> all outputs zero; Start then Tick with Rand=1000 -> Spawn=1000.
